// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction memory:
//   IMEM_ADDR_W / IMEM_DATA_W : default word-address and instruction widths
//   NOP                       : value returned for unimplemented addresses
//   DEFAULT_PROG              : the fixed boot program (18 words)
//   rom_word(addr)            : program word at addr, NOP past the program end
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DATA_W = 32;

  localparam logic [IMEM_DATA_W-1:0] NOP = 32'h0000_0000;

  localparam int unsigned PROG_LEN   = 18;
  localparam int          PROG_IDX_W = $clog2(PROG_LEN);

  localparam logic [IMEM_DATA_W-1:0] DEFAULT_PROG [PROG_LEN] = '{
    32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025, 32'h00642824, 32'h00a42820,
    32'h10a7000a, 32'h0064202a, 32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
    32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011, 32'h20020001, 32'hac020054
  };

  // Index is narrowed to the program-table width; the range test keeps
  // aliased addresses from ever selecting a program word.
  function automatic logic [IMEM_DATA_W-1:0] rom_word(input int unsigned addr);
    logic [PROG_IDX_W-1:0] idx;
    idx = addr[PROG_IDX_W-1:0];
    if (addr < PROG_LEN) return DEFAULT_PROG[idx];
    return NOP;
  endfunction

endpackage

// File: rtl/imem_if.sv
// ---------------------------------------------------------------------------
// imem_if
// Fetch/load bus of the instruction memory.
//   a       : read word address          (master -> slave)
//   y       : instruction at address a   (slave  -> master)
//   ld_we   : load write enable          (master -> slave)
//   ld_addr : load word address          (master -> slave)
//   ld_data : load data                  (master -> slave)
// ---------------------------------------------------------------------------
interface imem_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) ();

  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] y;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  modport master (output a, ld_we, ld_addr, ld_data, input  y);
  modport slave  (input  a, ld_we, ld_addr, ld_data, output y);

endinterface

// File: rtl/imem_overlay.sv
// ---------------------------------------------------------------------------
// imem_overlay
// Writable overlay for the instruction ROM: a DEPTH-word RAM plus one valid
// bit per word. Valid bits clear asynchronously on reset low; the RAM
// contents are kept. Loads to ld_addr_i >= DEPTH are dropped.
//   clk       : load clock
//   reset     : asynchronous active-low, clears all valid bits, blocks loads
//   ld_we_i   : load write enable
//   ld_addr_i : load word address
//   ld_data_i : load data
//   rd_addr_i : read word address
//   hit_o     : rd_addr_i is in range and its overlay word is valid
//   data_o    : overlay word at rd_addr_i (meaningful only when hit_o)
// ---------------------------------------------------------------------------
module imem_overlay
  import imem_pkg::*;
#(
  parameter int          ADDR_W = IMEM_ADDR_W,
  parameter int          DATA_W = IMEM_DATA_W,
  parameter int unsigned DEPTH  = 2**IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] ovl_mem_q [DEPTH];
  logic [DEPTH-1:0]  ovl_valid_q, ovl_valid_d;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              rd_in_range;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    wr_en       = reset && ld_we_i && (32'(ld_addr_i) < DEPTH);
    wr_idx      = ld_addr_i[IDX_W-1:0];
    ovl_valid_d = ovl_valid_q;
    if (wr_en) ovl_valid_d[wr_idx] = 1'b1;
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovl_valid_q <= '0;
    else        ovl_valid_q <= ovl_valid_d;
  end

  // NOTE: the data array is deliberately not reset; the valid bits are the
  // only thing reset has to clear, and a reset array would not map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) ovl_mem_q[wr_idx] <= ld_data_i;
  end

  // Combinational read: a load becomes visible right after its clock edge.
  always_comb begin
    rd_idx      = rd_addr_i[IDX_W-1:0];
    rd_in_range = 32'(rd_addr_i) < DEPTH;
    hit_o       = rd_in_range && ovl_valid_q[rd_idx];
    data_o      = ovl_mem_q[rd_idx];
  end

endmodule

// File: rtl/imem.sv
// ---------------------------------------------------------------------------
// imem
// 64 x 32 instruction memory for the single-cycle fetch stage. Reads are
// purely combinational: y = instruction at word address a, NOP beyond DEPTH.
// Build option: define IMEM_LOAD_EN to add the clocked load port and overlay
// RAM (imem_overlay); otherwise the block is a pure ROM and clk, reset and
// the ld_* signals are ignored.
//   clk   : clock for the load/overlay logic only
//   reset : asynchronous active-low, discards all overlay words
//   bus   : imem_if.slave (a, y, ld_we, ld_addr, ld_data)
// ---------------------------------------------------------------------------
module imem
  import imem_pkg::*;
#(
  parameter int          ADDR_W = IMEM_ADDR_W,
  parameter int          DATA_W = IMEM_DATA_W,
  parameter int unsigned DEPTH  = 2**IMEM_ADDR_W
) (
  input logic   clk,
  input logic   reset,
  imem_if.slave bus
);

  logic              in_range;
  logic [DATA_W-1:0] rom_y;

  always_comb begin
    in_range = 32'(bus.a) < DEPTH;
    rom_y    = in_range ? rom_word(32'(bus.a)) : NOP;
  end

`ifdef IMEM_LOAD_EN
  logic              ovl_hit;
  logic [DATA_W-1:0] ovl_data;

  imem_overlay #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_overlay (
    .clk       (clk),
    .reset     (reset),
    .ld_we_i   (bus.ld_we),
    .ld_addr_i (bus.ld_addr),
    .ld_data_i (bus.ld_data),
    .rd_addr_i (bus.a),
    .hit_o     (ovl_hit),
    .data_o    (ovl_data)
  );

  // ovl_hit already implies in range, so unloaded or unimplemented words
  // never select the (possibly uninitialised) overlay data.
  assign bus.y = ovl_hit ? ovl_data : rom_y;
`else
  // Pure ROM: the load-side inputs stay on the interface but drive nothing.
  logic unused_load_inputs;
  assign unused_load_inputs = ^{clk, reset, bus.ld_we, bus.ld_addr, bus.ld_data};
  assign bus.y = rom_y;
`endif

endmodule

// File: tb/tb_imem.sv
// ---------------------------------------------------------------------------
// tb_imem
// Drives two instances (DEPTH=64 and DEPTH=32) from the same stimulus and
// compares both against a word-array model of the memory. Works with and
// without IMEM_LOAD_EN.
// ---------------------------------------------------------------------------
module tb_imem;

`ifdef IMEM_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  // Expected boot program, padded to the full address space with NOPs.
  localparam logic [31:0] ROM_REF [64] = '{
    0: 32'h20020005,  1: 32'h2003000c,  2: 32'h2067fff7,  3: 32'h00e22025,
    4: 32'h00642824,  5: 32'h00a42820,  6: 32'h10a7000a,  7: 32'h0064202a,
    8: 32'h10800001,  9: 32'h20050000, 10: 32'h00e2202a, 11: 32'h00853820,
   12: 32'h00e23822, 13: 32'hac670044, 14: 32'h8c020050, 15: 32'h08000011,
   16: 32'h20020001, 17: 32'hac020054, default: 32'h00000000
  };

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic [5:0]  a       = '0;
  logic        ld_we   = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: per-instance overlay words and their valid flags.
  bit          mv64 [64];
  logic [31:0] mm64 [64];
  bit          mv32 [32];
  logic [31:0] mm32 [32];

  always #5 clk = ~clk;

  imem_if #(.ADDR_W(6), .DATA_W(32)) if64 ();
  imem_if #(.ADDR_W(6), .DATA_W(32)) if32 ();

  assign if64.a = a;  assign if64.ld_we = ld_we;  assign if64.ld_addr = ld_addr;  assign if64.ld_data = ld_data;
  assign if32.a = a;  assign if32.ld_we = ld_we;  assign if32.ld_addr = ld_addr;  assign if32.ld_data = ld_data;

  imem #(.ADDR_W(6), .DATA_W(32), .DEPTH(64)) u_dut64 (.clk(clk), .reset(reset), .bus(if64));
  imem #(.ADDR_W(6), .DATA_W(32), .DEPTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(if32));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: a=%0d got %08h expected %08h at %0t", name, a, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp64(input logic [5:0] addr);
    return mv64[addr] ? mm64[addr] : ROM_REF[addr];
  endfunction

  function automatic logic [31:0] exp32(input logic [5:0] addr);
    logic [4:0] i;
    i = addr[4:0];
    if (addr >= 6'd32) return 32'h0;
    return mv32[i] ? mm32[i] : ROM_REF[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mv64[i] = 1'b0;
    for (int i = 0; i < 32; i++) mv32[i] = 1'b0;
  endtask

  // Applies the load (if any) that the current clock edge captures.
  task automatic model_edge();
    if (LOAD_EN && reset && ld_we) begin
      mv64[ld_addr] = 1'b1;
      mm64[ld_addr] = ld_data;
      if (ld_addr < 6'd32) begin
        mv32[ld_addr[4:0]] = 1'b1;
        mm32[ld_addr[4:0]] = ld_data;
      end
    end
  endtask

  task automatic set_reset(input bit v);
    reset = v;
    if (!v) model_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Inputs only ever change off the falling edge, so y is settled here.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_y64", if64.y, exp64(a));
      check("cycle_y32", if32.y, exp32(a));
    end
  end

  initial begin
    logic [5:0]  pin_a [6];
    logic [31:0] pin_y [6];
    pin_a = '{6'd0, 6'd2, 6'd15, 6'd17, 6'd18, 6'd26};
    pin_y = '{32'h20020005, 32'h2067fff7, 32'h08000011, 32'hac020054, 32'h0, 32'h0};

    model_reset();
    cmp_en = 1'b1;
    repeat (2) tick();
    check("reset_a0", if64.y, 32'h20020005);
    @(negedge clk); #1 set_reset(1'b1);

    // ROM sweep.
    for (int i = 0; i <= 26; i++) begin
      @(negedge clk); #1 a = 6'(i);
      #1;
      check("sweep64", if64.y, exp64(a));
      check("sweep32", if32.y, exp32(a));
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1 a = pin_a[i];
      #1 check("rom_pin", if64.y, pin_y[i]);
    end

    // Combinational read: no clock edge between the two reads.
    @(negedge clk); #1 a = 6'd3;
    #1 check("comb_a3", if64.y, 32'h00e22025);
    a = 6'd4;
    #1 check("comb_a4", if64.y, 32'h00642824);

    // Single load to word 5.
    @(negedge clk); #1 a = 6'd5; ld_we = 1'b1; ld_addr = 6'd5; ld_data = 32'hDEADBEEF;
    #1 check("pre_load", if64.y, 32'h00a42820);
    tick();
    ld_we = 1'b0;
    #1;
    check("post_load64", if64.y, LOAD_EN ? 32'hDEADBEEF : 32'h00a42820);
    check("post_load32", if32.y, LOAD_EN ? 32'hDEADBEEF : 32'h00a42820);
    a = 6'd6;
    #1 check("neighbour_a6", if64.y, 32'h10a7000a);

    // Reset between edges discards the overlay; loads are blocked meanwhile.
    a = 6'd5;
    @(negedge clk); #2 set_reset(1'b0);
    #1;
    check("rst_revert64", if64.y, 32'h00a42820);
    check("rst_revert32", if32.y, 32'h00a42820);
    ld_we = 1'b1; ld_addr = 6'd5; ld_data = 32'h12345678;
    tick();
    ld_we = 1'b0;
    #1 check("rst_blocks_load", if64.y, 32'h00a42820);
    @(negedge clk); #1 set_reset(1'b1);
    #1 check("after_rst", if64.y, 32'h00a42820);

    // First edge after reset release accepts a load.
    ld_we = 1'b1; ld_addr = 6'd7; ld_data = 32'h0BADF00D;
    tick();
    ld_we = 1'b0; a = 6'd7;
    #1 check("first_load", if64.y, LOAD_EN ? 32'h0BADF00D : 32'h0064202a);

    // Load beyond DEPTH=32 is dropped there but lands in the 64-word copy.
    @(negedge clk); #1 ld_we = 1'b1; ld_addr = 6'd40; ld_data = 32'hCAFEF00D;
    tick();
    ld_we = 1'b0; a = 6'd40;
    #1;
    check("oor32", if32.y, 32'h0);
    check("oor64", if64.y, LOAD_EN ? 32'hCAFEF00D : 32'h0);
    a = 6'd8;
    #1 check("alias32_a8", if32.y, 32'h10800001);

    // Repeated loads to word 0: ignored without the load feature.
    ld_we = 1'b1; ld_addr = 6'd0; ld_data = 32'h11111111;
    tick();
    ld_data = 32'hFFFFFFFF;
    repeat (2) tick();
    ld_we = 1'b0; a = 6'd0;
    #1 check("last_write_a0", if64.y, LOAD_EN ? 32'hFFFFFFFF : 32'h20020005);

    // Randomised phase with occasional asynchronous reset pulses.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      model_edge();
      #1;
      a       = 6'($urandom_range(0, 63));
      ld_we   = ($urandom_range(0, 2) == 0);
      ld_addr = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      ld_data = $urandom;
      if (!reset) set_reset(1'b1);
      else if ($urandom_range(0, 39) == 0) begin
        #2 set_reset(1'b0);
      end
      #1;
      check("rand64", if64.y, exp64(a));
      check("rand32", if32.y, exp32(a));
    end

    ld_we = 1'b0;
    set_reset(1'b1);
    repeat (2) tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem.md
Name: imem

Overview:
- 64-word x 32-bit instruction memory feeding the single-cycle core's fetch stage.
- Reads are combinational: PC word address in, instruction out, within the same cycle.
- A fixed default program is held as constant ROM contents.
- An optional clocked load port overlays individual words; asynchronous reset discards every overlay.

Parameters:
- ADDR_W, 6, word-address width.
- DATA_W, 32, instruction width.
- DEPTH, 64, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock; used only by the load/overlay logic.
- reset  in  1  asynchronous, active-low; clears all overlay-valid bits.
- a  in  ADDR_W  read word address (PC[7:2] at the core level).
- y  out  DATA_W  instruction at address a.
- ld_we  in  1  load write enable (optional feature).
- ld_addr  in  ADDR_W  load word address.
- ld_data  in  DATA_W  load data.

Behaviour:
- Read path is purely combinational, with zero cycles latency.
  - Within DEPTH: y = ovl_valid[a] ? ovl_mem[a] : ROM[a].
  - a >= DEPTH: y = NOP (32'h00000000).
  - y changes whenever a, an overlay word or an overlay-valid bit changes. No clock edge is needed for reads.
- Default ROM contents, words 0..17:
  - 0-5: 20020005, 2003000c, 2067fff7, 00e22025, 00642824, 00a42820
  - 6-11: 10a7000a, 0064202a, 10800001, 20050000, 00e2202a, 00853820
  - 12-17: 00e23822, ac670044, 8c020050, 08000011, 20020001, ac020054
  - Words 18..DEPTH-1 are 00000000.
- Load (feature enabled): on posedge clk with reset high, ld_we=1 and ld_addr<DEPTH:
  - ovl_mem[ld_addr] <= ld_data;
  - ovl_valid[ld_addr] <= 1.
- Load to ld_addr >= DEPTH is silently ignored.
- Repeated load to the same address: last write wins.
- Read-during-write at the same address: y shows the old value until the edge and the new value immediately after it.
- reset low:
  - All ovl_valid bits clear immediately (asynchronous), so y reverts to ROM contents with no clock edge.
  - ovl_mem contents are not cleared.
  - Loads are blocked while reset is low. reset wins over a simultaneous ld_we.
- Reset deassertion is taken synchronously to clk. The first load is accepted on the first posedge after reset is sampled high.
- No X ever reaches y. ROM and out-of-range entries are fully defined; overlay data is only selected when its valid bit is set.

Optional Feature:
- Macro: IMEM_LOAD_EN.
- Defined: the overlay memory, the 64 valid bits and the load logic are built as described above.
- Undefined:
  - Pure ROM: y = ROM[a], or NOP for out-of-range addresses.
  - clk, reset and the ld_* ports remain on the interface but are ignored.
  - No storage is inferred.

Decomposition:
- Shared package imem_pkg holds:
  - IMEM_ADDR_W=6 and IMEM_DATA_W=32;
  - NOP = 32'h00000000;
  - DEFAULT_PROG, the constant array of the 18 program words above;
  - a function rom_word(addr) that returns DEFAULT_PROG[addr], or NOP past the end of the program.
- One natural sub-module: imem_overlay. It contains the overlay RAM, the valid-bit vector, the async reset and the load port. It is instantiated only under IMEM_LOAD_EN.
- The top level is the ROM lookup plus the output mux.

Test Plan:
- After reset, sweep a=0..26, each held 100 ps. Required: y follows the listed ROM words, e.g. a=0 -> 20020005, a=2 -> 2067fff7, a=15 -> 08000011, a=17 -> ac020054. a=18..26 -> 00000000.
- Combinational timing: change a from 3 to 4 with no clk edge. Required: y goes from 00e22025 to 00642824 within the same delta/timestep.
- Load (IMEM_LOAD_EN): ld_we=1, ld_addr=5, ld_data=DEADBEEF for one posedge, with a=5. Required: y=00a42820 before the edge and DEADBEEF after it; a=6 stays 10a7000a.
- Reset mid-operation: after the load above, pull reset low between clock edges. Required: y at a=5 returns to 00a42820 immediately. A ld_we pulse applied while reset is low has no effect.
- Out-of-range: with DEPTH=32, load ld_addr=40 and then read a=40. Required: y=00000000 and no other word changes.
- Macro undefined: toggle clk with ld_we=1, ld_addr=0, ld_data=FFFFFFFF. Required: a=0 still reads 20020005.
